// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780-style LCD bus scheduler.
// Holds the FSM state enum, panel command bytes, init ROM and wait-class helper.
// No logic state lives here; the optional init sequence is enabled by LCD_INIT_SEQ_EN.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_POWERUP,
    ST_INIT,
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_WAIT
  } lcd_state_e;

  localparam logic [7:0] FUNC_SET   = 8'h38;
  localparam logic [7:0] DISP_ON    = 8'h0C;
  localparam logic [7:0] CLEAR      = 8'h01;
  localparam logic [7:0] ENTRY_MODE = 8'h06;
  localparam logic [7:0] HOME       = 8'h02;
  localparam logic [7:0] LINE2_ADDR = 8'hC0;

  localparam int INIT_LEN = 6;

  // Power-on init ROM: function set three times, display on, clear, entry mode.
  function automatic logic [7:0] init_byte(input logic [2:0] idx);
    logic [7:0] b;
    case (idx)
      3'd0, 3'd1, 3'd2: b = FUNC_SET;
      3'd3:             b = DISP_ON;
      3'd4:             b = CLEAR;
      3'd5:             b = ENTRY_MODE;
      default:          b = FUNC_SET;
    endcase
    return b;
  endfunction

  // Clear and home (0x02, and 0x03 whose low bit the panel ignores) are the
  // slow instructions; everything else completes in the short wait.
  function automatic logic needs_long_wait(input logic rs, input logic [7:0] data);
    return !rs && (data == CLEAR || data == HOME || data == 8'h03);
  endfunction

endpackage

// File: rtl/lcd_bus_scheduler_if.sv
// Client request handshake plus LCD pin bundle for the bus scheduler.
// Ports: req_valid/req_rs/req_data/req_ready per client, lcd_data/lcd_rs/lcd_en pins.
// master = client/panel side, slave = scheduler side.
interface lcd_bus_scheduler_if;
  logic [1:0]  req_valid;
  logic [1:0]  req_rs;
  logic [15:0] req_data;
  logic [1:0]  req_ready;
  logic [7:0]  lcd_data;
  logic        lcd_rs;
  logic        lcd_en;

  modport master (
    output req_valid, req_rs, req_data,
    input  req_ready, lcd_data, lcd_rs, lcd_en
  );

  modport slave (
    input  req_valid, req_rs, req_data,
    output req_ready, lcd_data, lcd_rs, lcd_en
  );
endinterface

// File: rtl/lcd_rr_arbiter.sv
// Two-way round-robin grant; pointer remembers the client served last.
// Latency: grant is combinational from valid and the pointer; pointer updates on transfer.
// Backpressure: ready only for the granted, valid client and only while en is high.
module lcd_rr_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] valid,
  output logic [1:0] ready,
  output logic       fire,
  output logic       gnt_idx
);

  logic last_q;

  always_comb begin
    gnt_idx = 1'b0;
    if (valid == 2'b11) begin
      gnt_idx = ~last_q;
    end else if (valid[1]) begin
      gnt_idx = 1'b1;
    end
    ready = 2'b00;
    if (en && valid[gnt_idx]) begin
      ready[gnt_idx] = 1'b1;
    end
    fire = |(valid & ready);
  end

  // Reset to "client 1 served last" so client 0 wins the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else if (fire) begin
      last_q <= gnt_idx;
    end
  end

endmodule

// File: rtl/lcd_bus_scheduler.sv
// Shares an HD44780 LCD bus between two byte clients, sequencing setup/enable/wait timing.
// Latency: en rises T_SETUP after transfer, falls T_PULSE later, idle after T_SHORT/T_LONG more.
// Backpressure: req_ready only in IDLE for the round-robin winner; LCD_INIT_SEQ_EN adds power-on init.
// Ports: clk, rst_n, bus (slave: client handshake + lcd pins), busy, init_done.
module lcd_bus_scheduler
  import lcd_pkg::*;
#(
  parameter int T_SETUP   = 2,
  parameter int T_PULSE   = 12,
  parameter int T_SHORT   = 2000,
  parameter int T_LONG    = 80000,
  parameter int T_POWERUP = 750000
) (
  input  logic               clk,
  input  logic               rst_n,
  lcd_bus_scheduler_if.slave bus,
  output logic               busy,
  output logic               init_done
);

  localparam int T_MAX_A = (T_SETUP > T_PULSE) ? T_SETUP : T_PULSE;
  localparam int T_MAX_B = (T_SHORT > T_LONG) ? T_SHORT : T_LONG;
  localparam int T_MAX_C = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
  localparam int T_MAX   = (T_MAX_C > T_POWERUP) ? T_MAX_C : T_POWERUP;
  localparam int CW      = $clog2(T_MAX) + 1;

  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t C_SETUP = cnt_t'(T_SETUP - 1);
  localparam cnt_t C_PULSE = cnt_t'(T_PULSE - 1);
  localparam cnt_t C_SHORT = cnt_t'(T_SHORT - 1);
  localparam cnt_t C_LONG  = cnt_t'(T_LONG - 1);

`ifdef LCD_INIT_SEQ_EN
  localparam lcd_state_e RST_STATE = ST_POWERUP;
  localparam cnt_t       RST_CNT   = cnt_t'(T_POWERUP - 1);
  localparam logic       RST_BUSY  = 1'b1;
`else
  localparam lcd_state_e RST_STATE = ST_IDLE;
  localparam cnt_t       RST_CNT   = '0;
  localparam logic       RST_BUSY  = 1'b0;
`endif

  lcd_state_e state_q, state_d;
  cnt_t       cnt_q, cnt_d;
  logic [7:0] data_q, data_d;
  logic       rs_q, rs_d;
  logic       en_q;

  logic [1:0] arb_ready;
  logic       arb_fire;
  logic       arb_gnt;

  lcd_rr_arbiter u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (state_q == ST_IDLE),
    .valid   (bus.req_valid),
    .ready   (arb_ready),
    .fire    (arb_fire),
    .gnt_idx (arb_gnt)
  );

  assign bus.req_ready = arb_ready;
  assign bus.lcd_data  = data_q;
  assign bus.lcd_rs    = rs_q;
  assign bus.lcd_en    = en_q;

`ifdef LCD_INIT_SEQ_EN
  logic [2:0] idx_q, idx_d;
  logic       init_done_q, init_done_d;
  assign init_done = init_done_q;
`else
  assign init_done = 1'b1;
`endif

  // Every state entry loads T-1; the state is left on the cycle the counter reads 0.
  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q != '0) ? cnt_q - cnt_t'(1) : cnt_q;
    data_d  = data_q;
    rs_d    = rs_q;
`ifdef LCD_INIT_SEQ_EN
    idx_d       = idx_q;
    init_done_d = init_done_q;
`endif
    case (state_q)
`ifdef LCD_INIT_SEQ_EN
      ST_POWERUP: begin
        if (cnt_q == '0) begin
          state_d = ST_INIT;
        end
      end
      ST_INIT: begin
        data_d  = init_byte(idx_q);
        rs_d    = 1'b0;
        state_d = ST_SETUP;
        cnt_d   = C_SETUP;
      end
`endif
      ST_IDLE: begin
        if (arb_fire) begin
          data_d  = arb_gnt ? bus.req_data[15:8] : bus.req_data[7:0];
          rs_d    = bus.req_rs[arb_gnt];
          state_d = ST_SETUP;
          cnt_d   = C_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          state_d = ST_PULSE;
          cnt_d   = C_PULSE;
        end
      end
      ST_PULSE: begin
        if (cnt_q == '0) begin
          state_d = ST_WAIT;
          cnt_d   = needs_long_wait(rs_q, data_q) ? C_LONG : C_SHORT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
`ifdef LCD_INIT_SEQ_EN
          // While init is running, WAIT loops back to INIT until the ROM is exhausted.
          if (!init_done_q) begin
            if (idx_q == 3'(INIT_LEN - 1)) begin
              init_done_d = 1'b1;
            end else begin
              idx_d   = idx_q + 3'd1;
              state_d = ST_INIT;
            end
          end
`endif
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RST_STATE;
      cnt_q   <= RST_CNT;
      data_q  <= 8'h00;
      rs_q    <= 1'b0;
      en_q    <= 1'b0;
      busy    <= RST_BUSY;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      rs_q    <= rs_d;
      en_q    <= (state_d == ST_PULSE);
      busy    <= (state_d != ST_IDLE);
    end
  end

`ifdef LCD_INIT_SEQ_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q       <= 3'd0;
      init_done_q <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      init_done_q <= init_done_d;
    end
  end
`endif

endmodule

// File: tb/tb_lcd_bus_scheduler.sv
// Bench for lcd_bus_scheduler: random and scripted client traffic against a timing model.
// Expected writes are queued when the model predicts a grant; a monitor pops them on lcd_en.
// Works with LCD_INIT_SEQ_EN defined or not.
module tb_lcd_bus_scheduler;

  localparam int TS  = 2;
  localparam int TP  = 3;
  localparam int TSH = 5;
  localparam int TLG = 20;
  localparam int TPU = 10;

`ifdef LCD_INIT_SEQ_EN
  localparam bit INIT_EN = 1'b1;
`else
  localparam bit INIT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  logic init_done;

  lcd_bus_scheduler_if bus ();

  lcd_bus_scheduler #(
    .T_SETUP   (TS),
    .T_PULSE   (TP),
    .T_SHORT   (TSH),
    .T_LONG    (TLG),
    .T_POWERUP (TPU)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .busy      (busy),
    .init_done (init_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One expected panel write: byte, and the edges at which en rises, falls and the bus frees.
  typedef struct packed {
    logic       rs;
    logic [7:0] data;
    int         rise;
    int         fall;
    int         fin;
    bit         chk_fin;
    bit         init;
    bit         last_init;
  } exp_t;

  exp_t sbq[$];

  logic [47:0] init_seq = 48'h38_38_38_0C_01_06;

  function automatic int wait_len(input logic rs, input logic [7:0] d);
    return (!rs && d >= 8'h01 && d <= 8'h03) ? TLG : TSH;
  endfunction

  // n = edge at which the byte lands on the pins.
  function automatic exp_t mk(input logic rs, input logic [7:0] d, input int n,
                              input bit ini, input bit lst);
    exp_t e;
    e.rs        = rs;
    e.data      = d;
    e.rise      = n + TS;
    e.fall      = e.rise + TP;
    e.fin       = e.fall + wait_len(rs, d);
    e.chk_fin   = !ini || lst;
    e.init      = ini;
    e.last_init = lst;
    return e;
  endfunction

  // ---------------- reference model: arbitration + expected write queue
  int free_edge = 0;
  bit fresh = 1'b1;
  bit last_srv = 1'b1;

  always begin : model
    int n;
    int g;
    exp_t e;
    logic [1:0] v;
    logic [1:0] er;
    @(negedge clk);
    if (!rst_n) begin
      sbq.delete();
      last_srv = 1'b1;
      fresh    = 1'b1;
    end else begin
      if (fresh) begin
        fresh     = 1'b0;
        free_edge = cyc;
        if (INIT_EN) begin
          n = cyc + TPU + 1;
          for (int k = 0; k < 6; k++) begin
            e = mk(1'b0, init_seq[47-8*k -: 8], n, 1'b1, k == 5);
            sbq.push_back(e);
            n = e.fin + 1;
            free_edge = e.fin;
          end
        end
      end
      v  = bus.req_valid;
      er = 2'b00;
      if (cyc >= free_edge) begin
        if (v == 2'b11) er = last_srv ? 2'b01 : 2'b10;
        else            er = v;
      end
      check("req_ready", {30'd0, bus.req_ready}, {30'd0, er});
      if (er != 2'b00) begin
        g = er[1] ? 1 : 0;
        e = mk(bus.req_rs[g], bus.req_data[8*g +: 8], cyc + 1, 1'b0, 1'b0);
        sbq.push_back(e);
        last_srv  = er[1];
        free_edge = e.fin;
      end
    end
  end

  // ---------------- monitor: compares pin activity with the queued expectations
  bit prev_en = 1'b0;
  bit prev_busy = 1'b0;
  bit active = 1'b0;
  exp_t cur;

  always begin : monitor
    @(negedge clk);
    if (!rst_n) begin
      prev_en   = 1'b0;
      prev_busy = busy;
      active    = 1'b0;
    end else begin
      if (bus.lcd_en && !prev_en) begin
        if (sbq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_pulse: data %0h rs %0b with nothing expected (cycle %0d)",
                   bus.lcd_data, bus.lcd_rs, cyc);
        end else begin
          cur    = sbq.pop_front();
          active = 1'b1;
          check("rise_cycle", cyc, cur.rise);
          check("lcd_data", {24'd0, bus.lcd_data}, {24'd0, cur.data});
          check("lcd_rs", {31'd0, bus.lcd_rs}, {31'd0, cur.rs});
          if (cur.init) check("init_done_low", {31'd0, init_done}, 32'd0);
        end
      end
      if (active && bus.lcd_en && prev_en)
        check("bus_stable", {23'd0, bus.lcd_rs, bus.lcd_data}, {23'd0, cur.rs, cur.data});
      if (active && !bus.lcd_en && prev_en)
        check("fall_cycle", cyc, cur.fall);
      if (active && !busy && prev_busy) begin
        if (cur.chk_fin) check("idle_cycle", cyc, cur.fin);
        if (cur.last_init) check("init_done_rise", {31'd0, init_done}, 32'd1);
        active = 1'b0;
      end
      prev_en   = bus.lcd_en;
      prev_busy = busy;
    end
  end

  // ---------------- client driver
  typedef enum int {M_OFF, M_SCRIPT, M_HOLD, M_RAND} mode_e;
  mode_e mode = M_OFF;
  logic [1:0] hold_mask = 2'b00;
  logic [8:0] script[$];

  always begin : driver
    logic [1:0] acc;
    @(negedge clk);
    acc = bus.req_valid & bus.req_ready;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      bus.req_valid = 2'b00;
    end else begin
      case (mode)
        M_SCRIPT: begin
          if (acc[0] && script.size() > 0) script.delete(0);
          bus.req_valid = {1'b0, script.size() > 0};
          if (script.size() > 0) begin
            bus.req_rs[0]       = script[0][8];
            bus.req_data[7:0]   = script[0][7:0];
          end
        end
        M_HOLD: begin
          bus.req_valid = hold_mask;
          bus.req_rs    = 2'b11;
          bus.req_data  = {8'h32, 8'h31};
        end
        M_RAND: begin
          for (int i = 0; i < 2; i++) begin
            if (acc[i] || (bus.req_valid[i] && $urandom_range(0, 7) == 0)) begin
              bus.req_valid[i] = 1'b0;
            end else if (!bus.req_valid[i] && $urandom_range(0, 2) == 0) begin
              bus.req_valid[i]      = 1'b1;
              bus.req_rs[i]         = 1'($urandom_range(0, 1));
              bus.req_data[8*i +: 8] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 3))
                                                                    : 8'($urandom_range(0, 255));
            end
          end
        end
        default: bus.req_valid = 2'b00;
      endcase
    end
  end

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while ((script.size() > 0 || sbq.size() > 0 || cyc < free_edge + 2) && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (k >= budget) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: %0d writes still expected after %0d cycles", sbq.size(), budget);
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    bit found;
    bus.req_valid = 2'b00;
    bus.req_rs    = 2'b00;
    bus.req_data  = 16'h0000;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_lcd_en", {31'd0, bus.lcd_en}, 32'd0);
    check("rst_lcd_data", {24'd0, bus.lcd_data}, 32'd0);
    check("rst_lcd_rs", {31'd0, bus.lcd_rs}, 32'd0);
    check("rst_req_ready", {30'd0, bus.req_ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, {31'd0, INIT_EN});
    check("rst_init_done", {31'd0, init_done}, {31'd0, !INIT_EN});
    rst_n = 1'b1;

    // Directed writes from client 0: data byte, then long/short wait selection.
    script.push_back(9'h141);
    script.push_back(9'h001);
    script.push_back(9'h101);
    script.push_back(9'h002);
    script.push_back(9'h003);
    script.push_back(9'h0C0);
    mode = M_SCRIPT;
    drain(3000);
    mode = M_OFF;

    // Contention: both clients hold valid, grants must alternate.
    hold_mask = 2'b11;
    mode = M_HOLD;
    run(120);
    mode = M_OFF;
    drain(500);

    // Lone client 1 served back-to-back.
    hold_mask = 2'b10;
    mode = M_HOLD;
    run(60);
    mode = M_OFF;
    drain(500);

    // Random traffic with withdrawals.
    mode = M_RAND;
    run(1500);
    mode = M_OFF;
    drain(500);

    // Reset in the middle of an enable pulse.
    hold_mask = 2'b01;
    mode = M_HOLD;
    found = 1'b0;
    for (int k = 0; k < 300 && !found; k++) begin
      @(negedge clk);
      if (bus.lcd_en) found = 1'b1;
    end
    if (!found) begin
      tests++;
      fails++;
      $display("FAIL midreset_pulse: lcd_en never rose within 300 cycles");
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_lcd_en", {31'd0, bus.lcd_en}, 32'd0);
    check("midrst_lcd_data", {24'd0, bus.lcd_data}, 32'd0);
    check("midrst_busy", {31'd0, busy}, {31'd0, INIT_EN});
    check("midrst_init_done", {31'd0, init_done}, {31'd0, !INIT_EN});
    mode = M_OFF;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    mode = M_RAND;
    run(400);
    mode = M_OFF;
    drain(500);

    check("queue_empty", sbq.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lcd_bus_scheduler.md
# lcd_bus_scheduler

Shares the HD44780-style character LCD bus between two byte-writing clients and drives the bus at the timing the panel requires. Optionally runs the power-on initialisation sequence itself before serving clients. Sits between the screen/message generators and the `lcd_data`/`lcd_rs`/`lcd_en` pins. Clients never touch the pins directly.

## Interface
- `T_SETUP`, default 2: cycles `lcd_rs`/`lcd_data` are stable before `lcd_en` rises (≥1).
- `T_PULSE`, default 12: cycles `lcd_en` is high (≥1).
- `T_SHORT`, default 2000: post-pulse wait for ordinary writes (≥1).
- `T_LONG`, default 80000: post-pulse wait for clear/home commands (≥1).
- `T_POWERUP`, default 750000: power-on wait before the first init command (≥1).
- `clk` in 1: system clock.
- `rst_n` in 1: reset. One clock; reset is asynchronous and active-low.
- `req_valid` in 2: per-client write request.
- `req_rs` in 2: per-client register select (0 = command, 1 = data).
- `req_data` in 16: per-client byte; client i uses bits [8i+7:8i].
- `req_ready` out 2: per-client accept.
- `busy` out 1: high whenever the FSM is not in IDLE.
- `init_done` out 1: panel initialised; clients may be served.
- `lcd_data` out 8: LCD data bus.
- `lcd_rs` out 1: LCD register select.
- `lcd_en` out 1: LCD enable strobe.

## Operation
- **FSM states**
  - POWERUP: wait `T_POWERUP` cycles, then go to INIT.
  - INIT: load the next init byte (rs = 0) into the pins, then go to SETUP.
  - IDLE: arbitrate client requests.
  - SETUP: `lcd_en` = 0 for `T_SETUP` cycles.
  - PULSE: `lcd_en` = 1 for `T_PULSE` cycles.
  - WAIT: `lcd_en` = 0 for `T_SHORT` or `T_LONG` cycles.
- **Init sequence:** 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06.
  - After WAIT of the last init byte: set `init_done` = 1, go to IDLE.
  - Otherwise, after WAIT go to INIT.
- **Long/short wait selection:** WAIT uses `T_LONG` when rs = 0 and data ∈ {0x01, 0x02, 0x03}. Otherwise it uses `T_SHORT`.
- **Arbitration in IDLE:** round-robin between the two clients.
  - `req_ready[i]` = 1 only for the granted client, and only while its `req_valid` is high. It is combinational from `req_valid` and the priority pointer.
  - Both clients valid: the client not served last wins.
  - Pointer resets to favour client 0.
  - Only one valid: that client wins regardless of the pointer.
- **Transfer:** occurs on `req_valid[i] & req_ready[i]` at a rising edge.
  - `req_rs[i]`/byte i are registered onto `lcd_rs`/`lcd_data`.
  - Pointer updates to i.
  - FSM moves to SETUP.
- **Bus stability:** `lcd_data`/`lcd_rs` hold their value through SETUP, PULSE and WAIT, and in IDLE until the next transfer.
- **Request rules:**
  - A client must hold `req_valid` and its data until ready.
  - Deasserting `req_valid` before acceptance withdraws the request; nothing is written.
- **Counter:** one shared down-counter, width `$clog2(max(all T_*))+1`. It loads T−1 on state entry, and the state exits when the counter reads 0.

## Timing
- **Reset values** (asynchronous, held while `rst_n` = 0):
  - `lcd_data` = 0x00, `lcd_rs` = 0, `lcd_en` = 0.
  - `req_ready` = 2'b00, `busy` = 1, `init_done` = 0.
  - FSM in POWERUP; pointer → client 0.
- **Client write, transfer at edge N:**
  - `lcd_en` rises at edge N+`T_SETUP`.
  - `lcd_en` falls at edge N+`T_SETUP`+`T_PULSE`.
  - FSM re-enters IDLE (busy = 0) at edge N+`T_SETUP`+`T_PULSE`+Twait.
  - Next transfer is possible at that edge plus 1.
- **Init byte:** INIT costs one extra cycle before SETUP.
- **`init_done` timing:** `init_done` rises on the same edge that enters IDLE.
- **Mid-operation reset:** `lcd_en` drops immediately and any partial write is lost. POWERUP restarts, including the full init sequence.
- **Outputs:** all registered except `req_ready`.

## Configuration
- **`LCD_INIT_SEQ_EN` defined:** the POWERUP/INIT states and the init ROM are compiled in; behaviour is as above.
- **Not defined:**
  - Reset state is IDLE, `busy` resets to 0, and `init_done` is constant 1.
  - `T_POWERUP` is unused.
  - Clients must issue the init sequence themselves.

## Structure
- **`lcd_pkg`:**
  - FSM state enum.
  - Command constants: FUNC_SET 0x38, DISP_ON 0x0C, CLEAR 0x01, ENTRY_MODE 0x06, HOME 0x02, LINE2_ADDR 0xC0.
  - Init ROM length (6).
- **Sub-module `lcd_rr_arbiter`:** 2-way round-robin grant with pointer register, pointer updated on transfer.

## Test plan
All tests use `T_SETUP`=2, `T_PULSE`=3, `T_SHORT`=5, `T_LONG`=20, `T_POWERUP`=10.
- **Init sequence** (macro on): release reset → `lcd_en` pulses 6 times with `lcd_data` 38,38,38,0C,01,06 and `lcd_rs` = 0. Gap after 01 is 20 cycles, others 5. `init_done` rises after the last WAIT.
- **Single write:** client 0 writes rs=1 0x41 → `lcd_en` high for exactly 3 cycles starting 2 cycles after acceptance. Next ready occurs 10 cycles after acceptance.
- **Contention:** both clients hold valid (0x31, 0x32) → sequence 0x31, 0x32, 0x31… alternates. A lone client 1 is served back-to-back.
- **Long wait:** client writes rs=0 0x01 → 20-cycle WAIT. rs=1 0x01 → 5-cycle WAIT.
- **Mid-operation reset:** assert `rst_n` low during PULSE → `lcd_en` = 0 with no clock edge. After release the init sequence restarts from 0x38.
- **Macro off:** `busy` = 0 and `req_ready` follows `req_valid` one cycle after reset release. No init pulses occur.
